// File: rtl/line_mem_responder.sv
// Line memory responder: loads LINES lines over a valid/ready stream, serves
// line and single-bit accesses for the current line, then streams lines out.
module line_mem_responder #(
  parameter int SIZE    = 5,
  parameter int MEMSIZE = 25,
  parameter int LINES   = 5,
  parameter int IDXW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [MEMSIZE-1:0] load_line,
  output logic               load_ready,
  input  logic               read_line,
  output logic [MEMSIZE-1:0] line_out,
  output logic               line_valid,
  input  logic               rd,
  input  logic               wr,
  input  logic [IDXW-1:0]    i_idx,
  input  logic [IDXW-1:0]    j_idx,
  input  logic               wr_bit,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               idx_err,
  input  logic               next_line,
  output logic [5:0]         count,
  output logic               dump_valid,
  output logic [MEMSIZE-1:0] dump_line,
  input  logic               dump_ready,
  output logic               done,
  input  logic               restart
);

  localparam int AW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int BW = $clog2(MEMSIZE);

  typedef enum logic [1:0] {LOAD, SERVE, DUMP, FINISH} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [5:0]         count_q, count_d;
  logic [MEMSIZE-1:0] line_out_q, line_out_d;
  logic               line_valid_q, line_valid_d;
  logic               bit_out_q, bit_out_d;
  logic               bit_valid_q, bit_valid_d;
  logic               idx_err_q, idx_err_d;

  logic [MEMSIZE-1:0] mem [LINES];

  logic [AW-1:0]      cur;
  logic [MEMSIZE-1:0] cur_line;
  logic [BW-1:0]      idx;
  logic               idx_ok;
  logic               load_fire;
  logic               bit_we;

  assign cur      = count_q[AW-1:0];
  assign cur_line = mem[cur];
  assign idx_ok   = (int'(i_idx) < SIZE) && (int'(j_idx) < SIZE);
  assign idx      = BW'(SIZE) * BW'(i_idx) + BW'(j_idx);

  // load_ready is decoded from state but forced low while reset is held.
  assign load_ready = (state_q == LOAD) && !rst;
  assign load_fire  = load_ready && load_valid;
  assign bit_we     = (state_q == SERVE) && wr && idx_ok;

  assign line_out   = line_out_q;
  assign line_valid = line_valid_q;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign idx_err    = idx_err_q;
  assign count      = count_q;
  assign dump_valid = (state_q == DUMP);
  assign dump_line  = mem[rptr_q];
  assign done       = (state_q == FINISH);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    line_out_d   = line_out_q;
    line_valid_d = 1'b0;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    idx_err_d    = 1'b0;
    case (state_q)
      LOAD: begin
        if (load_fire) begin
          wptr_d = wptr_q + AW'(1);
          if (wptr_q == AW'(LINES - 1)) begin
            state_d = SERVE;
            count_d = '0;
          end
        end
      end
      SERVE: begin
        // All requests below use count_q and the memory as it was before this edge.
        if (read_line) begin
          line_out_d   = cur_line;
          line_valid_d = 1'b1;
        end
        if (rd) begin
          bit_valid_d = 1'b1;
          if (idx_ok) begin
            bit_out_d = cur_line[idx];
          end else begin
            bit_out_d = 1'b0;
            idx_err_d = 1'b1;
          end
        end
        if (wr && !idx_ok) idx_err_d = 1'b1;
        if (next_line) begin
          if (count_q == 6'(LINES - 1)) begin
            state_d = DUMP;
            rptr_d  = '0;
          end else begin
            count_d = count_q + 6'd1;
          end
        end
      end
      DUMP: begin
        if (dump_ready) begin
          if (rptr_q == AW'(LINES - 1)) state_d = FINISH;
          else                          rptr_d  = rptr_q + AW'(1);
        end
      end
      FINISH: begin
        if (restart) begin
          state_d = LOAD;
          wptr_d  = '0;
          rptr_d  = '0;
          count_d = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      line_out_q   <= '0;
      line_valid_q <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      idx_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      line_out_q   <= line_out_d;
      line_valid_q <= line_valid_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      idx_err_q    <= idx_err_d;
    end
  end

  // NOTE: the line store has no reset; its contents survive rst and are rewritten by the next load.
  always_ff @(posedge clk) begin
    if (load_fire)   mem[wptr_q]   <= load_line;
    else if (bit_we) mem[cur][idx] <= wr_bit;
  end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
Memory-side responder for the lane-permutation controller. It holds LINES lines of MEMSIZE bits each and loads them over a valid/ready stream. It then serves the controller's line reads and single-bit read/write requests, addressed by (i,j) within the current line. After the controller advances past the last line, it streams the updated lines out over a valid/ready dump port.

Parameters:
SIZE, 5, row/column dimension; bit index = SIZE*i + j
MEMSIZE, 25, bits per line (must equal SIZE*SIZE)
LINES, 5, number of lines stored (2..63)
IDXW, 3, width of i/j index ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
load_valid  in  1  load_line is valid
load_line  in  MEMSIZE  line to store at the write pointer
load_ready  out  1  block accepts load data (high only in LOAD)
read_line  in  1  request current line (controller readLine)
line_out  out  MEMSIZE  registered copy of mem[count]
line_valid  out  1  one-cycle pulse; line_out is valid
rd  in  1  bit read request
wr  in  1  bit write request
i_idx  in  IDXW  row index
j_idx  in  IDXW  column index
wr_bit  in  1  data for a bit write
bit_out  out  1  registered read data
bit_valid  out  1  one-cycle pulse; bit_out is valid
idx_err  out  1  one-cycle pulse; rd/wr had an out-of-range index
next_line  in  1  advance to the next line (controller enCount)
count  out  6  index of the current line
dump_valid  out  1  dump_line is valid
dump_line  out  MEMSIZE  line at the read pointer
dump_ready  in  1  consumer accepts dump_line
done  out  1  level; all lines dumped
restart  in  1  leave FINISH and return to LOAD

Behaviour:
- States: LOAD, SERVE, DUMP, FINISH.
- Reset (asynchronous):
  - state=LOAD; wptr, rptr and count = 0.
  - line_out, bit_out, line_valid, bit_valid, idx_err, dump_valid, done = 0.
  - load_ready=1 immediately after reset (decoded from state); 0 while rst is high.
  - Memory contents are not cleared.
- Reset mid-operation aborts any activity. No output pulse may be emitted on the edge on which rst is released.
- LOAD:
  - A handshake occurs when load_valid && load_ready: mem[wptr] <= load_line, wptr++.
  - On the handshake with wptr==LINES-1: go to SERVE, count <= 0.
  - rd, wr, read_line and next_line are ignored; no pulses are produced.
- SERVE (every request in a cycle uses count as it was before any increment in that cycle):
  - read_line: next cycle line_out = mem[count] and line_valid=1 for exactly one cycle. line_out holds its value until the next read_line.
  - idx = SIZE*i_idx + j_idx. An index is valid iff i_idx<SIZE and j_idx<SIZE.
  - rd with a valid index: next cycle bit_out = mem[count][idx], bit_valid=1.
  - wr with a valid index: mem[count][idx] <= wr_bit at this edge.
  - rd and wr in the same cycle with the same idx: read-before-write; bit_out returns the old bit.
  - read_line and wr in the same cycle: line_out carries the pre-write value.
  - rd or wr with an invalid index: no memory change. Next cycle idx_err=1 and bit_valid=1 with bit_out=0 (rd case).
  - next_line: count++. If count==LINES-1, go instead to DUMP with rptr=0, and count stays at LINES-1.
  - load_valid is ignored; load_ready=0.
- DUMP:
  - dump_valid=1 and dump_line=mem[rptr] combinationally from the registered rptr.
  - On dump_valid && dump_ready: rptr++. Handshake at rptr==LINES-1 goes to FINISH.
  - dump_line must be stable while dump_valid=1 && dump_ready=0.
  - SERVE-side requests are ignored.
- FINISH:
  - done=1, dump_valid=0.
  - restart: go to LOAD, zero wptr, rptr and count; done falls next cycle.
  - restart in any state other than FINISH is ignored.
- Latency: line/bit reads take 1 cycle. Loading and dumping sustain 1 line/cycle when the partner keeps valid/ready high.

Test Plan:
- Reset, then load 5 lines 25'h0000001, 25'h0000002, 25'h0000004, 25'h0000008, 25'h0000010 back-to-back → load_ready drops the cycle after the 5th handshake; state SERVE; count=0.
- SERVE, count=0, read_line → next cycle line_out=25'h0000001, line_valid high exactly 1 cycle.
- wr i=4 j=4 wr_bit=1 together with rd i=4 j=4 → bit_out=0 (old value); a following read_line returns 25'h1000001.
- rd i=5 j=0 → idx_err=1 and bit_out=0 next cycle; wr i=0 j=7 leaves line_out unchanged on re-read.
- Issue 5 next_line pulses with read_line on the 5th → line_out=mem[4]; state DUMP. Hold dump_ready=0 for 3 cycles → dump_line stable at line 0. Then dump_ready=1 → lines 0..4 emitted on consecutive cycles, then done=1.
- Assert rst mid-DUMP (rptr=2) → all outputs 0 at once, load_ready=1 after release. restart in FINISH → done=0 next cycle, new load accepted at wptr=0.
